// File: rtl/div_iter_if.sv
// Handshake bundle between the execute-stage divider and its issuing pipeline.
// The master drives the operands and control; the slave returns the stall, status and HI/LO result.
interface div_iter_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             div_stall;
  logic             busy;
  logic             res_valid;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, signed_div, a, b, cancel,
    input  div_stall, busy, res_valid, hi_o, lo_o
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output div_stall, busy, res_valid, hi_o, lo_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) that feeds the HI/LO register file.
// The quotient goes out on lo_o and the remainder on hi_o, with a single res_valid pulse.
//   state  | meaning
//   S_IDLE | waiting for start; a zero divisor goes straight to S_DONE
//   S_BUSY | one restoring step per cycle, 32 steps in total
//   S_DONE | result registered, res_valid high for this one cycle
module div_iter #(parameter int WIDTH = 32) (
  input  logic       i_clk,
  input  logic       i_rst,
  div_iter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [5:0]         r_cnt;
  logic [2*WIDTH-1:0] r_rq, w_rq_step;
  logic [WIDTH-1:0]   r_dvs, r_hi, r_lo;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_diff, w_quo, w_rem;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge, w_dbz, w_last, w_stall;
  logic               r_q_neg, r_r_neg, r_busy, r_res_valid;

  assign w_dbz   = (bus.b == '0);
  assign w_last  = (r_cnt == 6'(WIDTH - 1));
  assign w_a_mag = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The shifted remainder needs 33 bits, but after a successful subtract it always fits back into 32.
  assign w_rem_sh  = r_rq[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_dvs;
  assign w_rq_step = w_ge ? {w_diff, r_rq[WIDTH-2:0], 1'b1} : {r_rq[2*WIDTH-2:0], 1'b0};
  assign w_quo     = w_rq_step[WIDTH-1:0];
  assign w_rem     = w_rq_step[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          w_stall     = 1'b1;
          w_state_nxt = w_dbz ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.cancel) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rq        <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
      if (!bus.cancel) begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (w_dbz) begin
                r_hi <= bus.a;
                r_lo <= '1;
              end else begin
                r_rq    <= {{WIDTH{1'b0}}, w_a_mag};
                r_dvs   <= w_b_mag;
                r_q_neg <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_r_neg <= bus.signed_div & bus.a[WIDTH-1];
                r_cnt   <= '0;
              end
            end
          end
          S_BUSY: begin
            r_rq  <= w_rq_step;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_lo <= r_q_neg ? -w_quo : w_quo;
              r_hi <= r_r_neg ? -w_rem : w_rem;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.div_stall = w_stall;
  assign bus.busy      = r_busy;
  assign bus.res_valid = r_res_valid;
  assign bus.hi_o      = r_hi;
  assign bus.lo_o      = r_lo;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: hand-computed DIV/DIVU results, divide-by-zero,
// cancel, reset and start-during-DONE behaviour.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) bus ();
  div_iter #(.WIDTH(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int cyc;
    int st;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = sgn; bus.a = a; bus.b = b;
    #1 chk({tag, "_stall_req"}, bus.div_stall, 1);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    cyc = 0;
    st  = 0;
    while (!bus.res_valid && cyc < 40) begin
      if (bus.div_stall) st++;
      cyc++;
      @(negedge clk);
      #1;
    end
    if (b != 0) begin
      chk({tag, "_latency"}, cyc, 32);
      chk({tag, "_stall_busy"}, st, 32);
    end else begin
      chk({tag, "_latency"}, 32'(cyc <= 1), 1);
      chk({tag, "_stall_busy"}, st, 0);
    end
    chk({tag, "_res_valid"}, bus.res_valid, 1);
    chk({tag, "_lo"}, bus.lo_o, eq);
    chk({tag, "_hi"}, bus.hi_o, er);
    chk({tag, "_done_stall"}, bus.div_stall, 0);
    chk({tag, "_done_busy"}, bus.busy, 1);
    @(negedge clk);
    #1;
    chk({tag, "_rv_drop"}, bus.res_valid, 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_lo_hold"}, bus.lo_o, eq);
    chk({tag, "_hi_hold"}, bus.hi_o, er);
  endtask

  initial begin
    int  cyc;
    logic seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.signed_div = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    chk("rst_stall", bus.div_stall, 0);
    rst = 1'b0;

    run_div("divu_100_7",    1'b0, 32'd100,         32'd7,         32'd14,        32'd2);
    run_div("div_m7_2",      1'b1, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2",      1'b1, 32'd7,           32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("div_min_m1",    1'b1, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_max_1",    1'b0, 32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF, 32'd0);
    run_div("div_m100_7",    1'b1, 32'hFFFF_FF9C,   32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_div("divu_big_max",  1'b0, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_div("div_m16_0",     1'b1, 32'hFFFF_FFF0,   32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF0);
    run_div("divu_1234_0",   1'b0, 32'h0000_1234,   32'd0,         32'hFFFF_FFFF, 32'h0000_1234);

    // cancel during step 10 of 50 / 3
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd50; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    #1 chk("cancel_stall_busy", bus.div_stall, 1);
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    chk("cancel_busy", bus.busy, 0);
    chk("cancel_rv", bus.res_valid, 0);
    chk("cancel_stall", bus.div_stall, 0);
    chk("cancel_hi", bus.hi_o, 32'h0000_1234);
    chk("cancel_lo", bus.lo_o, 32'hFFFF_FFFF);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk("cancel_no_rv", seen, 0);
    chk("cancel_hi_later", bus.hi_o, 32'h0000_1234);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);

    // start and cancel together in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.a = 32'd5; bus.b = 32'd1;
    #1 chk("sc_stall", bus.div_stall, 0);
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    #1;
    chk("sc_busy", bus.busy, 0);
    chk("sc_lo", bus.lo_o, 32'd2);

    // reset in the middle of BUSY
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rv", bus.res_valid, 0);
    chk("mid_rst_hi", bus.hi_o, 0);
    chk("mid_rst_lo", bus.lo_o, 0);
    chk("mid_rst_stall", bus.div_stall, 0);

    // start held high through DONE
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    #1;
    cyc = 0;
    while (!bus.res_valid && cyc < 40) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("hold_rv", bus.res_valid, 1);
    chk("hold_done_stall", bus.div_stall, 0);
    chk("hold_lo", bus.lo_o, 32'd14);
    @(negedge clk);
    #1;
    chk("hold_idle_busy", bus.busy, 0);
    chk("hold_idle_stall", bus.div_stall, 1);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("hold_reaccept_busy", bus.busy, 1);
    chk("hold_reaccept_rv", bus.res_valid, 0);
    cyc = 0;
    while (!bus.res_valid && cyc < 40) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("hold_second_rv", bus.res_valid, 1);
    chk("hold_second_hi", bus.hi_o, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
